// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: skid state encoding and default width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int PIPE_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/pipe_slot.sv
// Payload register with load enable; cleared by reset so the output is never X.
module pipe_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready stage with a two-entry skid buffer; every handshake output is a flop,
// so out_ready never reaches in_ready combinationally.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    skid_state_t      state;
    skid_state_t      state_nxt;
    logic             in_fire;
    logic             out_fire;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = HALF;
                    load_main = 1'b1;
                end
            end
            HALF: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt      = HALF;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush only clears validity; payload registers keep their stale contents.
        if (flush) begin
            state_nxt = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
        end
    end

    assign occupancy = state;

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (load_main),
        .d    (main_d),
        .q    (out_data)
    );

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (load_skid),
        .d    (in_data),
        .q    (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios with literal expectations plus a
// queue-based FIFO model compared against the outputs every cycle.
module tb_pipe_skid_stage;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;

    int checks = 0;
    int errors = 0;

    pipe_skid_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of capacity 2; ready/valid are what the held count was
    // before the edge, flush empties it, reset empties it at once.
    logic [WIDTH-1:0] mq[$];
    logic             m_in_fire;
    logic             m_out_fire;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_in_fire  = in_valid && (mq.size() < 2);
            m_out_fire = out_ready && (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_fire) void'(mq.pop_front());
                if (m_in_fire) mq.push_back(in_data);
            end
        end
    end

    logic             p_valid;
    logic [WIDTH-1:0] p_data;
    logic             p_stall;
    logic             p_have = 1'b0;

    always @(negedge clk) begin
        chk("model_occupancy", 32'(occupancy), 32'(mq.size()));
        chk("model_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("model_in_ready", 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() > 0) chk("model_out_data", out_data, mq[0]);
        if (p_have && p_stall && !rst) begin
            chk("stall_valid", 32'(out_valid), 32'(p_valid));
            chk("stall_data", out_data, p_data);
        end
        p_valid = out_valid;
        p_data  = out_data;
        p_stall = out_valid && !out_ready && !flush && !rst;
        p_have  = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        tick();

        // streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h10; tick();
        chk("stream_d10", out_data, 32'h10);
        chk("stream_rdy0", 32'(in_ready), 32'd1);
        in_data   = 32'h11; tick();
        chk("stream_d11", out_data, 32'h11);
        chk("stream_rdy1", 32'(in_ready), 32'd1);
        in_data   = 32'h12; tick();
        chk("stream_d12", out_data, 32'h12);
        chk("stream_v12", 32'(out_valid), 32'd1);
        in_valid  = 1'b0; tick();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h20; tick();
        chk("bp_occ1", 32'(occupancy), 32'd1);
        in_data   = 32'h21; tick();
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_rdy_low", 32'(in_ready), 32'd0);
        chk("bp_head", out_data, 32'h20);
        in_data   = 32'h22; tick();
        chk("bp_hold_occ", 32'(occupancy), 32'd2);
        out_ready = 1'b1; tick();
        chk("bp_out21", out_data, 32'h21);
        chk("bp_rdy_back", 32'(in_ready), 32'd1);
        tick();
        chk("bp_out22", out_data, 32'h22);
        chk("bp_occ_22", 32'(occupancy), 32'd1);
        in_valid  = 1'b0; tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // flush while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h30; tick();
        in_data   = 32'h31; tick();
        chk("fl_full", 32'(occupancy), 32'd2);
        flush     = 1'b1;
        in_data   = 32'h32; tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_rdy", 32'(in_ready), 32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0; tick();
        chk("fl_no32", 32'(occupancy), 32'd0);
        chk("fl_stale", out_data, 32'h30);

        // simultaneous in/out in HALF
        in_valid  = 1'b1;
        in_data   = 32'h40; tick();
        chk("sim_main40", out_data, 32'h40);
        in_data   = 32'h41;
        out_ready = 1'b1; tick();
        chk("sim_out41", out_data, 32'h41);
        chk("sim_occ1", 32'(occupancy), 32'd1);
        in_valid  = 1'b0; tick();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA1; tick();
        in_data   = 32'hA2; tick();
        in_valid  = 1'b0;
        chk("ar_full", 32'(occupancy), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_occ", 32'(occupancy), 32'd0);
        chk("ar_data", out_data, 32'd0);
        chk("ar_rdy", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("final_empty", 32'(occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
